// File: rtl/phase_a_scheduler.sv
// phase_a_scheduler: round-robin arbiter and pass sequencer in front of one
// shared phase_a reduction instance. A granted job's operand is run through
// phase_a the programmed number of times and the final value is returned to
// the owning requester with a one-cycle done pulse.
// Optional build macro: PA_TIMEOUT_EN adds a WAIT-state watchdog and a sticky
// err flag; without it err is tied low and WAIT waits indefinitely.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no job; arbitrate among pending requests
// S_LAUNCH | pa_en high for this single cycle, pa_a holds the operand
// S_WAIT   | pa_en low, waiting for pa_en_out to capture the result
// S_FINISH | publish op on res_a and pulse done for the owner next cycle

module phase_a_scheduler #(
    parameter int Size      = 3072,
    parameter int NREQ      = 4,
    parameter int ITER_W    = 8,
    parameter int TO_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*Size-1:0]     req_a,
    input  logic [NREQ*ITER_W-1:0]   req_iter,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [Size-1:0]          res_a,
    output logic                     busy,
    output logic                     pa_en,
    output logic [Size-1:0]          pa_a,
    input  logic [Size-1:0]          pa_new_a,
    input  logic                     pa_en_out,
    output logic                     err
);

    localparam int IDX_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    owner;
    logic [IDX_W-1:0]    sel;
    logic [IDX_W-1:0]    ptr_next;
    logic                found;
    logic [Size-1:0]     op;
    logic [ITER_W-1:0]   cnt;
    logic [Size-1:0]     sel_a;
    logic [ITER_W-1:0]   sel_iter;
    logic [NREQ-1:0]     sel_oh;
    logic [NREQ-1:0]     owner_oh;
    int                  scan_idx;
    logic [IDX_W-1:0]    scan_w;

`ifdef PA_TIMEOUT_EN
    localparam int WD_W = $clog2(TO_CYCLES + 1);
    logic [WD_W-1:0]     wd;
    logic                err_q;
    assign err = err_q;
`else
    logic unused_to_cycles;
    assign unused_to_cycles = (TO_CYCLES > 0);
    assign err = 1'b0;
`endif

    assign busy = (state != S_IDLE);

    // Round-robin pick: first pending request at or after the pointer, wrapping.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_idx = 0;
        scan_w   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(ptr) + k) % NREQ;
            scan_w   = IDX_W'(scan_idx);
            if (!found && req[scan_w]) begin
                found = 1'b1;
                sel   = scan_w;
            end
        end
    end

    assign ptr_next = (sel == IDX_W'(NREQ - 1)) ? '0 : sel + 1'b1;
    assign sel_a    = req_a[int'(sel)*Size +: Size];
    assign sel_iter = req_iter[int'(sel)*ITER_W +: ITER_W];
    assign sel_oh   = {{(NREQ-1){1'b0}}, 1'b1} << sel;
    assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner;

    // Sequencer FSM with registered gnt/done/pa_en/pa_a/res_a outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ptr   <= '0;
            owner <= '0;
            op    <= '0;
            cnt   <= '0;
            gnt   <= '0;
            done  <= '0;
            res_a <= '0;
            pa_en <= 1'b0;
            pa_a  <= '0;
`ifdef PA_TIMEOUT_EN
            wd    <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt   <= sel_oh;
                        owner <= sel;
                        op    <= sel_a;
                        cnt   <= sel_iter;
                        ptr   <= ptr_next;
                        if (sel_iter == '0) begin
                            state <= S_FINISH;
                        end else begin
                            state <= S_LAUNCH;
                            pa_en <= 1'b1;
                            pa_a  <= sel_a;
                        end
                    end
                end
                S_LAUNCH: begin
                    pa_en <= 1'b0;
                    state <= S_WAIT;
`ifdef PA_TIMEOUT_EN
                    wd    <= WD_W'(TO_CYCLES - 1);
`endif
                end
                S_WAIT: begin
                    if (pa_en_out) begin
                        op  <= pa_new_a;
                        cnt <= cnt - 1'b1;
                        if (cnt == ITER_W'(1)) begin
                            state <= S_FINISH;
                        end else begin
                            // Relaunch goes through LAUNCH, so pa_en was low
                            // for at least this WAIT cycle: a fresh rising edge.
                            state <= S_LAUNCH;
                            pa_en <= 1'b1;
                            pa_a  <= pa_new_a;
                        end
                    end
`ifdef PA_TIMEOUT_EN
                    else if (wd == '0) begin
                        err_q <= 1'b1;
                        res_a <= op;
                        done  <= owner_oh;
                        state <= S_IDLE;
                    end else begin
                        wd <= wd - 1'b1;
                    end
`endif
                end
                S_FINISH: begin
                    res_a <= op;
                    done  <= owner_oh;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_a_scheduler.sv
// tb_phase_a_scheduler: randomized scoreboard bench for phase_a_scheduler with
// a behavioural phase_a model (result = operand + k_add after 'lat' cycles).
// Build with PA_TIMEOUT_EN to also exercise the watchdog.

module tb_phase_a_scheduler;

    localparam int SIZE = 3072;
    localparam int NREQ = 4;
    localparam int IW   = 8;
    localparam int TO   = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*SIZE-1:0]   req_a;
    logic [NREQ*IW-1:0]     req_iter;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [SIZE-1:0]        res_a;
    logic                   busy;
    logic                   pa_en;
    logic [SIZE-1:0]        pa_a;
    logic [SIZE-1:0]        pa_new_a;
    logic                   pa_en_out;
    logic                   err;

    phase_a_scheduler #(
        .Size(SIZE), .NREQ(NREQ), .ITER_W(IW), .TO_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_iter(req_iter),
        .gnt(gnt), .done(done), .res_a(res_a), .busy(busy), .pa_en(pa_en),
        .pa_a(pa_a), .pa_new_a(pa_new_a), .pa_en_out(pa_en_out), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // phase_a model controls
    logic [SIZE-1:0] k_add;
    int              lat;
    bit              mute;
    bit              hold_mode;

    // outstanding jobs as the requesters see them
    bit              job_valid [NREQ];
    logic [SIZE-1:0] job_a     [NREQ];
    int              job_n     [NREQ];

    typedef struct {
        int              owner;
        logic [SIZE-1:0] res;
        int              n;
    } exp_t;
    exp_t sb_q[$];

    int m_ptr;
    int grant_log[$];
    int done_cnt;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req_v, $time);
        end
    endtask

    function automatic logic [SIZE-1:0] rand_op();
        logic [SIZE-1:0] r;
        r = '0;
        for (int w = 0; w < SIZE/32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic bit any_pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < NREQ; i++) if (job_valid[i]) p = 1'b1;
        return p;
    endfunction

    task automatic issue(input int i, input logic [SIZE-1:0] a, input int n);
        req_a[i*SIZE +: SIZE] = a;
        req_iter[i*IW +: IW]  = IW'(n);
        job_a[i]     = a;
        job_n[i]     = n;
        job_valid[i] = 1'b1;
        req[i]       = 1'b1;
    endtask

    // One cycle of stimulus: advance to the falling edge, then retire granted requests.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                if (hold_mode) issue(i, rand_op(), 1);
                else           req[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while ((busy || req != '0 || sb_q.size() != 0 || any_pending()) && c < budget) begin
            step();
            c++;
        end
        chk(c < budget, "wait_idle_bound", 64'(c), 64'(budget));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(gnt == '0,   {tag, "_gnt"},   64'(gnt),   64'h0);
        chk(done == '0,  {tag, "_done"},  64'(done),  64'h0);
        chk(busy == 1'b0, {tag, "_busy"}, 64'(busy),  64'h0);
        chk(pa_en == 1'b0, {tag, "_pa_en"}, 64'(pa_en), 64'h0);
        chk(err == 1'b0, {tag, "_err"},   64'(err),   64'h0);
        chk(res_a == '0, {tag, "_res_a"}, res_a[63:0], 64'h0);
        chk(pa_a == '0,  {tag, "_pa_a"},  pa_a[63:0],  64'h0);
    endtask

    // Grant monitor: predicts the round-robin winner and queues the expected result.
    initial begin : gnt_mon
        int              w;
        int              idx;
        logic [NREQ-1:0] oh;
        exp_t            e;
        m_ptr = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                m_ptr = 0;
            end else if (gnt != '0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (w < 0 && job_valid[idx]) w = idx;
                end
                chk($onehot(gnt), "gnt_onehot", 64'(gnt), 64'h1);
                if (w < 0) begin
                    chk(1'b0, "gnt_without_request", 64'(gnt), 64'h0);
                end else begin
                    oh = '0;
                    oh[w] = 1'b1;
                    chk(gnt == oh, "gnt_round_robin", 64'(gnt), 64'(oh));
                    e.owner = w;
                    e.n     = job_n[w];
                    e.res   = job_a[w];
                    if (!mute) for (int j = 0; j < job_n[w]; j++) e.res = e.res + k_add;
                    sb_q.push_back(e);
                    job_valid[w] = 1'b0;
                    m_ptr = (w + 1) % NREQ;
                    grant_log.push_back(w);
                end
            end
        end
    end

    // Done monitor: pops the scoreboard and checks owner, result, pass count and timing.
    initial begin : done_mon
        int              en_cnt;
        int              since;
        int              exp_pulses;
        bit              prev_en;
        logic [NREQ-1:0] prev_gnt;
        logic [NREQ-1:0] oh;
        exp_t            e;
        en_cnt = 0; since = 0; prev_en = 1'b0; prev_gnt = '0; done_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                sb_q.delete();
                en_cnt = 0; since = 0; prev_en = 1'b0; prev_gnt = '0;
            end else begin
                if (pa_en) begin
                    chk(!prev_en, "pa_en_low_between_launches", 64'(prev_en), 64'h0);
                    en_cnt++;
                end
                if (gnt != '0) since = 0;
                else           since++;
                if (done != '0) begin
                    done_cnt++;
                    if (sb_q.size() == 0) begin
                        chk(1'b0, "done_unexpected", 64'(done), 64'h0);
                    end else begin
                        e = sb_q.pop_front();
                        oh = '0;
                        oh[e.owner] = 1'b1;
                        chk(done == oh, "done_owner", 64'(done), 64'(oh));
                        chk(res_a == e.res, "res_a", res_a[63:0], e.res[63:0]);
                        exp_pulses = mute ? ((e.n > 0) ? 1 : 0) : e.n;
                        chk(en_cnt == exp_pulses, "pa_en_count", 64'(en_cnt), 64'(exp_pulses));
                        if (e.n == 0)
                            chk(prev_gnt == oh, "zero_iter_done_latency", 64'(prev_gnt), 64'(oh));
                        if (mute && e.n > 0)
                            chk(since == TO + 1, "watchdog_latency", 64'(since), 64'(TO + 1));
                    end
                    en_cnt = 0;
                end
            end
            prev_en  = pa_en;
            prev_gnt = gnt;
        end
    end

    // phase_a model: capture pa_a on a launch, answer 'lat' cycles later.
    initial begin : pa_model
        logic [SIZE-1:0] m_a0;
        bit              m_ab;
        int              m_l;
        pa_en_out = 1'b0;
        pa_new_a  = '0;
        forever begin
            @(negedge clk);
            pa_en_out = 1'b0;
            if (pa_en && !mute) begin
                m_a0 = pa_a;
                m_ab = rst;
                m_l  = lat;
                for (int j = 1; j < m_l; j++) begin
                    @(negedge clk);
                    if (rst) m_ab = 1'b1;
                end
                if (!m_ab) chk(pa_a == m_a0, "pa_a_stable", pa_a[63:0], m_a0[63:0]);
                pa_new_a  = m_a0 + k_add;
                pa_en_out = 1'b1;
            end
        end
    end

    initial begin : global_guard
        #900000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int issued;
        int cyc;
        int r_i;
        int dc;
        int c;
        rst = 1'b1; req = '0; req_a = '0; req_iter = '0;
        k_add = SIZE'(5); lat = 19; mute = 1'b0; hold_mode = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            job_valid[i] = 1'b0; job_a[i] = '0; job_n[i] = 0;
        end
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // single pass, +5 after 19 cycles
        issue(0, rand_op(), 1);
        step();
        chk(gnt == 4'b0001, "single_gnt_latency", 64'(gnt), 64'h1);
        wait_idle(200);

        // three passes, +1 each
        k_add = SIZE'(1);
        lat   = $urandom_range(2, 8);
        issue(2, rand_op(), 3);
        wait_idle(300);

        // zero passes
        issue(1, rand_op(), 0);
        wait_idle(50);

        // round robin with all requests held
        rst = 1'b1; step(); step(); rst = 1'b0; step();
        grant_log.delete();
        lat = 3;
        hold_mode = 1'b1;
        for (int i = 0; i < NREQ; i++) issue(i, rand_op(), 1);
        c = 0;
        while (grant_log.size() < 5 && c < 500) begin step(); c++; end
        hold_mode = 1'b0;
        chk(c < 500, "rr_grant_bound", 64'(c), 64'd500);
        wait_idle(500);
        for (int j = 0; j < 5; j++)
            if (j < grant_log.size())
                chk(grant_log[j] == j % NREQ, "rr_order", 64'(grant_log[j]), 64'(j % NREQ));

        // reset in WAIT, then a stray pa_en_out
        lat = 19;
        issue(3, rand_op(), 2);
        c = 0;
        while (!pa_en && c < 20) begin step(); c++; end
        chk(pa_en == 1'b1, "reset_test_launch", 64'(pa_en), 64'h1);
        repeat (5) step();
        chk(busy == 1'b1, "reset_test_busy_in_wait", 64'(busy), 64'h1);
        rst = 1'b1;
        step();
        check_reset_outputs("midjob_reset");
        rst = 1'b0;
        dc = done_cnt;
        repeat (40) step();
        chk(done_cnt == dc, "no_done_after_reset", 64'(done_cnt), 64'(dc));
        chk(busy == 1'b0, "idle_after_stray", 64'(busy), 64'h0);
        issue(0, rand_op(), 1);
        wait_idle(200);

        // randomized traffic
        k_add  = rand_op();
        issued = 0;
        cyc    = 0;
        while (issued < 60 && cyc < 20000) begin
            step();
            cyc++;
            lat = $urandom_range(2, 12);
            if ($urandom_range(0, 2) == 0) begin
                r_i = $urandom_range(0, NREQ - 1);
                if (!req[r_i] && !job_valid[r_i]) begin
                    issue(r_i, rand_op(), $urandom_range(0, 4));
                    issued++;
                end
            end
        end
        chk(issued == 60, "random_jobs_issued", 64'(issued), 64'd60);
        wait_idle(3000);

`ifdef PA_TIMEOUT_EN
        mute = 1'b1;
        issue(1, rand_op(), 1);
        wait_idle(200);
        chk(err == 1'b1, "watchdog_err", 64'(err), 64'h1);
        repeat (10) step();
        chk(err == 1'b1, "watchdog_err_sticky", 64'(err), 64'h1);
        rst = 1'b1;
        step();
        chk(err == 1'b0, "watchdog_err_cleared", 64'(err), 64'h0);
        rst = 1'b0;
        mute = 1'b0;
        step();
`else
        step();
        chk(err == 1'b0, "err_tied_low", 64'(err), 64'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
